counter_arbiter: RTL

//  Round-robin controller that shares one up-counter (clock/reset/enable/out) among
//  N requesters. Each requester asks for a run of LEN counts. The block grants one

---
 rtl/counter_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/counter_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and defaults for the counter arbiter
package counter_pkg;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter
  import counter_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 any
);

  int idx;

  // Walk the requesters starting at ptr, wrapping modulo N; the first set bit wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx[$clog2(N)-1:0];
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - shares one up-counter among N requesters in round-robin runs
module counter_arbiter
  import counter_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   len,
  input  logic [WIDTH-1:0]     cnt_value,
  output logic                 cnt_clear,
  output logic                 cnt_enable,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(N)-1:0] done_id
);

  localparam int IDW = $clog2(N);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [N-1:0]     gnt_q, gnt_d;

  logic [N-1:0]     arb_gnt;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;

  rr_arbiter #(
    .N (N)
  ) u_rr_arbiter (
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  // State, owner, run length and round-robin pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state and output decode; outputs depend only on state so reset clears them at once.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    gnt_d      = gnt_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    grant      = '0;
    busy       = 1'b0;
    done       = 1'b0;
    done_id    = '0;
    case (state_q)
      IDLE: begin
        // req and len are only looked at here; later changes cannot disturb a run.
        if (arb_any) begin
          id_d    = arb_id;
          gnt_d   = arb_gnt;
          len_d   = len[arb_id*WIDTH +: WIDTH];
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        grant     = gnt_q;
        busy      = 1'b1;
        cnt_clear = 1'b1;
        state_d   = COUNT;
      end
      COUNT: begin
        grant = gnt_q;
        busy  = 1'b1;
        // Stop enabling as soon as the target is reached so the counter cannot overshoot or wrap.
        cnt_enable = (cnt_value != len_q);
        if (cnt_value == len_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        grant   = gnt_q;
        busy    = 1'b1;
        done    = 1'b1;
        done_id = id_q;
        if (id_q == IDW'(N - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = id_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
